md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have parameter MULT_LAT, default 5, busy cycles for multiply-class ops (legal range 1..15).
REQ-003 SHALL have parameter DIV_LAT, default 10, busy cycles for divide-class ops (legal range 1..15).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request qualifying op/a/b.
REQ-007 SHALL have port op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11-15 reserved.
REQ-008 SHALL have port a  input  WIDTH  rs operand (mthi/mtlo source).
REQ-009 SHALL have port b  input  WIDTH  rt operand.
REQ-010 SHALL have port busy  output  1  registered; high while an op is in flight.
REQ-011 SHALL have port hi  output  WIDTH  registered HI.
REQ-012 SHALL have port lo  output  WIDTH  registered LO.

Function
REQ-013 SHALL be IDLE/RUN FSM: IDLE->RUN on accepted start of ops 1-4 or 7-10; RUN->IDLE when counter reaches 1.
REQ-014 SHALL accept start only in IDLE; start while busy is ignored (no state change), hazard logic guarantees it is held off.
REQ-015 SHALL, on accept, latch a, b, op and load counter with MULT_LAT (ops 1,2,7-10) or DIV_LAT (ops 3,4).
REQ-016 SHALL assert busy from the edge after accept for exactly LAT cycles; counter decrements once per cycle in RUN.
REQ-017 SHALL keep hi/lo at pre-op values during RUN and write results on the edge that clears busy.
REQ-018 SHALL, for mult/multu, set {hi,lo} = signed/unsigned 2*WIDTH-bit product.
REQ-019 SHALL, for div/divu, set lo = quotient truncated toward zero, hi = remainder with dividend's sign (signed case).
REQ-020 SHALL, on divide by zero, leave hi and lo unchanged but still run DIV_LAT busy cycles.
REQ-021 SHALL, for signed most-negative / -1, set lo = most-negative value, hi = 0, no trap.
REQ-022 SHALL, for mthi/mtlo accepted in IDLE, write a to hi/lo on the next edge with busy staying 0.
REQ-023 SHALL treat op 0 and reserved ops as no-op, even with start high.
REQ-024 SHALL compute madd/msub (when enabled) as {hi,lo} +/- product, modulo 2^(2*WIDTH), using {hi,lo} sampled at completion.

Reset
REQ-025 SHALL, when reset is high at an edge, force FSM IDLE, counter 0, busy 0, hi 0, lo 0.
REQ-026 SHALL abort any in-flight op on reset with no result written; reset dominates a same-cycle start.

Configuration
REQ-027 SHALL compile ops 7-10 only when macro MD_UNIT_MADD_EN is defined.
REQ-028 SHALL, without MD_UNIT_MADD_EN, treat ops 7-10 as reserved no-ops (busy stays 0, hi/lo unchanged).

Verification
REQ-029 SHALL cover: WIDTH=32, start op=1 a=0xFFFFFFFF b=2 -> busy high 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE.
REQ-030 SHALL cover: op=2 a=0xFFFFFFFF b=2 -> hi=0x00000001 lo=0xFFFFFFFE after 5 cycles.
REQ-031 SHALL cover: op=3 a=-7 b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; then op=3 b=0 -> hi/lo unchanged.
REQ-032 SHALL cover: op=3 a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0; second start mid-run ignored.
REQ-033 SHALL cover: op=5 a=0x12345678 -> hi=0x12345678 next edge, busy 0; reset at busy cycle 3 of a mult -> busy 0, hi=lo=0.
REQ-034 SHALL cover: with MD_UNIT_MADD_EN, hi=0 lo=1, op=7 a=3 b=4 -> lo=13; without macro -> lo stays 1, busy never rises.

Source files
------------

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO result registers.
// Optional multiply-accumulate ops 7-10 are compiled only with MD_UNIT_MADD_EN.
module md_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_UNIT_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif
  localparam logic [3:0]       MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0]       DIV_CNT  = 4'(DIV_LAT);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;

  logic             is_mul, is_div;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, b_mag_safe, b_u_safe;
  logic [WIDTH-1:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign is_mul = (op == OP_MULT) || (op == OP_MULTU)
`ifdef MD_UNIT_MADD_EN
               || (op >= OP_MADD && op <= OP_MSUBU)
`endif
               ;
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);

  // Low 2*WIDTH bits of a sign-extended unsigned product equal the signed product.
  assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // Signed divide via magnitudes; most-negative / -1 falls out as most-negative, rem 0.
  assign a_neg      = a_q[WIDTH-1];
  assign b_neg      = b_q[WIDTH-1];
  assign a_mag      = a_neg ? (~a_q + ONE) : a_q;
  assign b_mag      = b_neg ? (~b_q + ONE) : b_q;
  assign b_mag_safe = (b_mag == '0) ? ONE : b_mag;
  assign b_u_safe   = (b_q == '0) ? ONE : b_q;
  assign q_mag      = a_mag / b_mag_safe;
  assign r_mag      = a_mag % b_mag_safe;
  assign q_s        = (a_neg ^ b_neg) ? (~q_mag + ONE) : q_mag;
  assign r_s        = a_neg ? (~r_mag + ONE) : r_mag;
  assign q_u        = a_q / b_u_safe;
  assign r_u        = a_q % b_u_safe;

`ifdef MD_UNIT_MADD_EN
  logic [2*WIDTH-1:0] hilo;
  assign hilo = {hi_q, lo_q};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mul || is_div) begin
            state_d = RUN;
            cnt_d   = is_div ? DIV_CNT : MULT_CNT;
            op_d    = op;
            a_d     = a;
            b_d     = b;
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      RUN: begin
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: if (b_q != '0) begin
              hi_d = r_s;
              lo_d = q_s;
            end
            OP_DIVU: if (b_q != '0) begin
              hi_d = r_u;
              lo_d = q_u;
            end
`ifdef MD_UNIT_MADD_EN
            OP_MADD:  {hi_d, lo_d} = hilo + prod_s;
            OP_MADDU: {hi_d, lo_d} = hilo + prod_u;
            OP_MSUB:  {hi_d, lo_d} = hilo - prod_s;
            OP_MSUBU: {hi_d, lo_d} = hilo - prod_u;
`endif
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit (WIDTH=32, default latencies).
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int tests_run = 0;
  int tests_failed = 0;

  md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op, then counts busy cycles; optionally injects a second start mid-run.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit inject, output int ncyc, output bit held);
    logic [31:0] hi0, lo0;
    hi0 = hi;
    lo0 = lo;
    held = 1'b1;
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = 4'd0; a = '0; b = '0;
    ncyc = 0;
    while (busy && ncyc < 40) begin
      if (hi !== hi0 || lo !== lo0) held = 1'b0;
      ncyc++;
      if (inject && ncyc == 2) begin
        start = 1'b1; op = 4'd4; a = 32'd100; b = 32'd7;
      end else begin
        start = 1'b0; op = 4'd0; a = '0; b = '0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h, required busy=0 hi=0 lo=0", busy, hi, lo);
    end
  endtask

  task automatic test_mult();
    int n; bit held;
    run_op(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0, n, held);
    tests_run++;
    if (n !== 5 || !held) begin
      tests_failed++;
      $display("FAIL mult_busy: cycles=%0d held=%0d, required 5 and 1", n, held);
    end
    tests_run++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
      tests_failed++;
      $display("FAIL mult_result: hi=%h lo=%h, required ffffffff fffffffe", hi, lo);
    end
    run_op(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0, n, held);
    tests_run++;
    if (n !== 5 || hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
      tests_failed++;
      $display("FAIL multu_result: cycles=%0d hi=%h lo=%h, required 5 00000001 fffffffe", n, hi, lo);
    end
  endtask

  task automatic test_div();
    int n; bit held;
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, n, held);
    tests_run++;
    if (n !== 10 || !held) begin
      tests_failed++;
      $display("FAIL div_busy: cycles=%0d held=%0d, required 10 and 1", n, held);
    end
    tests_run++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      tests_failed++;
      $display("FAIL div_neg: hi=%h lo=%h, required ffffffff fffffffd", hi, lo);
    end
    run_op(4'd3, 32'h00000005, 32'd0, 1'b0, n, held);
    tests_run++;
    if (n !== 10 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      tests_failed++;
      $display("FAIL div_by_zero: cycles=%0d hi=%h lo=%h, required 10 ffffffff fffffffd", n, hi, lo);
    end
    run_op(4'd3, 32'd7, 32'hFFFFFFFE, 1'b0, n, held);
    tests_run++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin
      tests_failed++;
      $display("FAIL div_neg_divisor: hi=%h lo=%h, required 00000001 fffffffd", hi, lo);
    end
    run_op(4'd4, 32'd100, 32'd7, 1'b0, n, held);
    tests_run++;
    if (n !== 10 || lo !== 32'd14 || hi !== 32'd2) begin
      tests_failed++;
      $display("FAIL divu_result: cycles=%0d hi=%h lo=%h, required 10 00000002 0000000e", n, hi, lo);
    end
  endtask

  task automatic test_div_overflow_and_busy_start();
    int n; bit held;
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, n, held);
    tests_run++;
    if (n !== 10 || lo !== 32'h80000000 || hi !== 32'h0) begin
      tests_failed++;
      $display("FAIL div_overflow_ignore_start: cycles=%0d hi=%h lo=%h, required 10 00000000 80000000", n, hi, lo);
    end
    tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignored_start_no_run: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_move();
    start = 1'b1; op = 4'd5; a = 32'h12345678;
    tick();
    start = 1'b0; op = 4'd0;
    tests_run++;
    if (hi !== 32'h12345678 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mthi: hi=%h busy=%b, required 12345678 0", hi, busy);
    end
    start = 1'b1; op = 4'd6; a = 32'hCAFEF00D;
    tick();
    start = 1'b0; op = 4'd0;
    tests_run++;
    if (lo !== 32'hCAFEF00D || hi !== 32'h12345678 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b, required 12345678 cafef00d 0", hi, lo, busy);
    end
  endtask

  task automatic test_noop();
    bit rose;
    rose = 1'b0;
    start = 1'b1; op = 4'd12; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b1; op = 4'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy) rose = 1'b1;
      tick();
    end
    tests_run++;
    if (rose || hi !== 32'h12345678 || lo !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL reserved_noop: busy_rose=%0d hi=%h lo=%h, required 0 12345678 cafef00d", rose, hi, lo);
    end
  endtask

  task automatic test_reset_abort();
    start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd3;
    tick();
    start = 1'b0; op = 4'd0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_abort: busy=%b hi=%h lo=%h, required 0 0 0", busy, hi, lo);
    end
    for (int i = 0; i < 8; i++) tick();
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_no_result: busy=%b hi=%h lo=%h, required 0 0 0", busy, hi, lo);
    end
    reset = 1'b1; start = 1'b1; op = 4'd1; a = 32'd5; b = 32'd5;
    tick();
    reset = 1'b0; start = 1'b0; op = 4'd0;
    tick();
    tests_run++;
    if (busy !== 1'b0 || lo !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_dominates_start: busy=%b lo=%h, required 0 0", busy, lo);
    end
  endtask

  task automatic test_madd();
    int n; bit held;
    start = 1'b1; op = 4'd5; a = 32'd0;
    tick();
    op = 4'd6; a = 32'd1;
    tick();
    start = 1'b0; op = 4'd0;
    run_op(4'd7, 32'd3, 32'd4, 1'b0, n, held);
`ifdef MD_UNIT_MADD_EN
    tests_run++;
    if (n !== 5 || lo !== 32'd13 || hi !== 32'd0) begin
      tests_failed++;
      $display("FAIL madd: cycles=%0d hi=%h lo=%h, required 5 00000000 0000000d", n, hi, lo);
    end
    run_op(4'd9, 32'd2, 32'd10, 1'b0, n, held);
    tests_run++;
    if (n !== 5 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF9) begin
      tests_failed++;
      $display("FAIL msub: cycles=%0d hi=%h lo=%h, required 5 ffffffff fffffff9", n, hi, lo);
    end
`else
    tests_run++;
    if (n !== 0 || lo !== 32'd1 || hi !== 32'd0) begin
      tests_failed++;
      $display("FAIL madd_disabled: cycles=%0d hi=%h lo=%h, required 0 00000000 00000001", n, hi, lo);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_overflow_and_busy_start();
    test_move();
    test_noop();
    test_reset_abort();
    test_madd();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
